// File: rtl/modbus_tx.sv
// Modbus RTU response framer: serialises normal and exception responses byte by
// byte toward a UART, fetching holding registers on demand and appending CRC-16/MODBUS.
module modbus_tx #(
    parameter logic [7:0] SLAVE_ADDR = 8'h02,
    parameter int         MAX_QTY    = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resp_send,
    input  logic        ex_send,
    input  logic [7:0]  func_code,
    input  logic [7:0]  ex_code,
    input  logic [15:0] start_addr_r,
    input  logic [15:0] quantity_r,
    input  logic [15:0] start_addr_w,
    input  logic [15:0] quantity_w,
    output logic        hr_rd_req,
    output logic [15:0] hr_rd_addr,
    input  logic [15:0] hr_rd_data,
    output logic [7:0]  txd,
    output logic        txv,
    input  logic        tx_rdy,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE, ADDR, FUNC, EXC, BCNT, FIELD, RD_REQ, RD_WAIT,
        DATA_HI, DATA_LO, CRC_LO, CRC_HI, DONE
    } state_t;

    typedef enum logic [1:0] {MODE_READ, MODE_W06, MODE_W10} mode_t;

    localparam logic [15:0] MAX_QTY_W = 16'(MAX_QTY);

    state_t      state, state_next;
    mode_t       mode;
    logic        is_exc;
    logic [7:0]  func_byte, exc_byte, bcnt_byte;
    logic [15:0] addr_w, qty_w, rd_cnt, word, crc;
    logic [1:0]  field_idx, field_last;
    logic [7:0]  cur_byte;
    logic        byte_state, accept, trigger;

    function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign accept  = txv && tx_rdy;
    assign trigger = ex_send || resp_send;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cur_byte   = 8'h00;
        byte_state = 1'b0;
        hr_rd_req  = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: if (trigger) state_next = ADDR;
            ADDR: begin
                byte_state = 1'b1;
                cur_byte   = SLAVE_ADDR;
                if (accept) state_next = FUNC;
            end
            FUNC: begin
                byte_state = 1'b1;
                cur_byte   = func_byte;
                if (accept) begin
                    if (is_exc)                 state_next = EXC;
                    else if (mode == MODE_READ) state_next = BCNT;
                    else                        state_next = FIELD;
                end
            end
            EXC: begin
                byte_state = 1'b1;
                cur_byte   = exc_byte;
                if (accept) state_next = CRC_LO;
            end
            BCNT: begin
                byte_state = 1'b1;
                cur_byte   = bcnt_byte;
                if (accept) state_next = RD_REQ;
            end
            FIELD: begin
                byte_state = 1'b1;
                case (field_idx)
                    2'd0:    cur_byte = addr_w[15:8];
                    2'd1:    cur_byte = addr_w[7:0];
                    2'd2:    cur_byte = qty_w[15:8];
                    default: cur_byte = qty_w[7:0];
                endcase
                // Function 06 echoes the address, then reads back the written word.
                if (accept && field_idx == field_last)
                    state_next = (mode == MODE_W06) ? RD_REQ : CRC_LO;
            end
            RD_REQ: begin
                hr_rd_req  = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: state_next = DATA_HI;
            DATA_HI: begin
                byte_state = 1'b1;
                cur_byte   = word[15:8];
                if (accept) state_next = DATA_LO;
            end
            DATA_LO: begin
                byte_state = 1'b1;
                cur_byte   = word[7:0];
                if (accept) state_next = (rd_cnt == 16'd1) ? CRC_LO : RD_REQ;
            end
            CRC_LO: begin
                byte_state = 1'b1;
                cur_byte   = crc[7:0];
                if (accept) state_next = CRC_HI;
            end
            CRC_HI: begin
                byte_state = 1'b1;
                cur_byte   = crc[15:8];
                if (accept) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request decode happens once at trigger; everything later uses the latched copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            txv        <= 1'b0;
            txd        <= 8'h00;
            crc        <= 16'hFFFF;
            hr_rd_addr <= 16'h0000;
            rd_cnt     <= 16'h0000;
            field_idx  <= 2'd0;
            field_last <= 2'd0;
            word       <= 16'h0000;
            func_byte  <= 8'h00;
            exc_byte   <= 8'h00;
            bcnt_byte  <= 8'h00;
            addr_w     <= 16'h0000;
            qty_w      <= 16'h0000;
            is_exc     <= 1'b0;
            mode       <= MODE_READ;
        end else begin
            if (state == IDLE && trigger) begin
                crc        <= 16'hFFFF;
                field_idx  <= 2'd0;
                field_last <= 2'd3;
                func_byte  <= func_code | 8'h80;
                exc_byte   <= ex_code;
                is_exc     <= 1'b1;
                mode       <= MODE_READ;
                bcnt_byte  <= {quantity_r[6:0], 1'b0};
                addr_w     <= start_addr_w;
                qty_w      <= quantity_w;
                rd_cnt     <= 16'h0000;
                hr_rd_addr <= start_addr_r;
                if (!ex_send) begin
                    case (func_code)
                        8'h03, 8'h17: begin
                            if (quantity_r == 16'h0000 || quantity_r > MAX_QTY_W) begin
                                exc_byte <= 8'h03;
                            end else begin
                                is_exc    <= 1'b0;
                                func_byte <= func_code;
                                rd_cnt    <= quantity_r;
                            end
                        end
                        8'h06: begin
                            is_exc     <= 1'b0;
                            func_byte  <= func_code;
                            mode       <= MODE_W06;
                            rd_cnt     <= 16'd1;
                            hr_rd_addr <= start_addr_w;
                            field_last <= 2'd1;
                        end
                        8'h10: begin
                            is_exc    <= 1'b0;
                            func_byte <= func_code;
                            mode      <= MODE_W10;
                        end
                        default: exc_byte <= 8'h01;
                    endcase
                end
            end

            if (state == RD_WAIT)
                word <= hr_rd_data;

            if (byte_state) begin
                if (accept) begin
                    txv <= 1'b0;
                    if (state != CRC_LO && state != CRC_HI)
                        crc <= crc_update(crc, txd);
                    if (state == FIELD)
                        field_idx <= field_idx + 2'd1;
                    if (state == DATA_LO) begin
                        hr_rd_addr <= hr_rd_addr + 16'd1;
                        rd_cnt     <= rd_cnt - 16'd1;
                    end
                end else if (!txv) begin
                    txv <= 1'b1;
                    txd <= cur_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_modbus_tx.sv
// Self-checking bench for modbus_tx: a frame-level model builds the expected byte
// stream and register reads, and a per-cycle monitor checks the UART handshake.
module tb_modbus_tx;

    localparam logic [7:0] SLAVE = 8'h02;

    logic        clk, rst;
    logic        resp_send, ex_send;
    logic [7:0]  func_code, ex_code;
    logic [15:0] start_addr_r, quantity_r, start_addr_w, quantity_w;
    logic        hr_rd_req;
    logic [15:0] hr_rd_addr, hr_rd_data;
    logic [7:0]  txd;
    logic        txv, tx_rdy, busy, done;

    modbus_tx dut (
        .clk(clk), .rst(rst), .resp_send(resp_send), .ex_send(ex_send),
        .func_code(func_code), .ex_code(ex_code),
        .start_addr_r(start_addr_r), .quantity_r(quantity_r),
        .start_addr_w(start_addr_w), .quantity_w(quantity_w),
        .hr_rd_req(hr_rd_req), .hr_rd_addr(hr_rd_addr), .hr_rd_data(hr_rd_data),
        .txd(txd), .txv(txv), .tx_rdy(tx_rdy), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_reads[$];

    logic        prev_txv = 1'b0, prev_acc = 1'b0, prev_req = 1'b0;
    logic [7:0]  prev_txd = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0005: return 16'hABCD;
            16'hFFFF: return 16'hBEEF;
            default:  return a ^ 16'hC3A5;
        endcase
    endfunction

    function automatic logic [15:0] crc16(input logic [7:0] data[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (data[k]) begin
            c = c ^ {8'h00, data[k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Register file responder: data appears the cycle after the strobe.
    always @(posedge clk)
        hr_rd_data <= hr_rd_req ? mem_word(hr_rd_addr) : 16'hDEAD;

    task automatic build_frame(input bit ex, input logic [7:0] fc, input logic [7:0] exc,
                               input logic [15:0] sar, input logic [15:0] qr,
                               input logic [15:0] saw, input logic [15:0] qw);
        logic [7:0]  f[$];
        logic [15:0] a, w, c;
        exp_reads.delete();
        f.push_back(SLAVE);
        if (ex) begin
            f.push_back(fc | 8'h80); f.push_back(exc);
        end else if (fc == 8'h03 || fc == 8'h17) begin
            if (qr == 0 || qr > 125) begin
                f.push_back(fc | 8'h80); f.push_back(8'h03);
            end else begin
                f.push_back(fc); f.push_back(8'((qr * 2) % 256));
                for (int i = 0; i < int'(qr); i++) begin
                    a = 16'((int'(sar) + i) % 65536);
                    w = mem_word(a);
                    exp_reads.push_back(a);
                    f.push_back(w[15:8]); f.push_back(w[7:0]);
                end
            end
        end else if (fc == 8'h06) begin
            w = mem_word(saw);
            exp_reads.push_back(saw);
            f.push_back(8'h06); f.push_back(saw[15:8]); f.push_back(saw[7:0]);
            f.push_back(w[15:8]); f.push_back(w[7:0]);
        end else if (fc == 8'h10) begin
            f.push_back(8'h10); f.push_back(saw[15:8]); f.push_back(saw[7:0]);
            f.push_back(qw[15:8]); f.push_back(qw[7:0]);
        end else begin
            f.push_back(fc | 8'h80); f.push_back(8'h01);
        end
        c = crc16(f);
        f.push_back(c[7:0]); f.push_back(c[15:8]);
        exp_q = f;
    endtask

    // Caller is just past a rising edge; the trigger is seen at the next edge.
    task automatic applyStimulus(input string name, input bit ex, input bit rs,
                                 input logic [7:0] fc, input logic [7:0] exc,
                                 input logic [15:0] sar, input logic [15:0] qr,
                                 input logic [15:0] saw, input logic [15:0] qw,
                                 input logic [7:0] lit[$]);
        $display("[TB] frame: %s", name);
        build_frame(ex, fc, exc, sar, qr, saw, qw);
        foreach (lit[i])
            checkOutput($sformatf("%s model byte %0d", name, i), 32'(exp_q[i]), 32'(lit[i]));
        acc_cnt = 0;
        done_cnt = 0;
        ex_send = ex; resp_send = rs; func_code = fc; ex_code = exc;
        start_addr_r = sar; quantity_r = qr; start_addr_w = saw; quantity_w = qw;
        @(posedge clk); #1;
        ex_send = 1'b0; resp_send = 1'b0;
        func_code = 8'($urandom); ex_code = 8'($urandom);
        start_addr_r = 16'($urandom); quantity_r = 16'($urandom);
        start_addr_w = 16'($urandom); quantity_w = 16'($urandom);
        checkOutput($sformatf("%s busy after trigger", name), 32'(busy), 32'd1);
    endtask

    task automatic wait_frame(input string name, input int rdy_mode);
        for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       tx_rdy = 1'($urandom_range(0, 1));
                2:       tx_rdy = !(c >= 10 && c < 60);
                default: tx_rdy = 1'b1;
            endcase
            resp_send = (c == 3);
            ex_send   = (c == 5);
        end
        resp_send = 1'b0; ex_send = 1'b0; tx_rdy = 1'b1;
        checkOutput($sformatf("%s done seen", name), 32'(done_cnt), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput($sformatf("%s single done", name), 32'(done_cnt), 32'd1);
        checkOutput($sformatf("%s bytes left", name), 32'(exp_q.size()), 32'd0);
        checkOutput($sformatf("%s reads left", name), 32'(exp_reads.size()), 32'd0);
        checkOutput($sformatf("%s idle busy", name), 32'(busy), 32'd0);
    endtask

    // Per-cycle handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_txv = 1'b0; prev_acc = 1'b0; prev_req = 1'b0;
        end else begin
            if (prev_txv && !prev_acc) begin
                checkOutput("txv held until accepted", 32'(txv), 32'd1);
                checkOutput("txd stable while stalled", 32'(txd), 32'(prev_txd));
            end
            if (prev_acc)
                checkOutput("gap after accept", 32'(txv), 32'd0);
            if (txv && tx_rdy) begin
                checkOutput("byte expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    checkOutput($sformatf("tx byte %0d", acc_cnt), 32'(txd), 32'(exp_q.pop_front()));
                acc_cnt++;
            end
            if (hr_rd_req) begin
                checkOutput("rd_req one cycle", 32'(prev_req), 32'd0);
                checkOutput("read expected", 32'(exp_reads.size() != 0), 32'd1);
                if (exp_reads.size() != 0)
                    checkOutput("rd addr", 32'(hr_rd_addr), 32'(exp_reads.pop_front()));
            end
            if (done) begin
                done_cnt++;
                checkOutput("busy during done", 32'(busy), 32'd1);
                checkOutput("all bytes before done", 32'(exp_q.size()), 32'd0);
            end
            prev_txv = txv; prev_acc = txv && tx_rdy; prev_req = hr_rd_req; prev_txd = txd;
        end
    end

    initial begin
        logic [7:0] lit[$];
        rst = 1'b1; tx_rdy = 1'b1; resp_send = 1'b0; ex_send = 1'b0;
        func_code = 8'h00; ex_code = 8'h00;
        start_addr_r = 16'h0000; quantity_r = 16'h0000;
        start_addr_w = 16'h0000; quantity_w = 16'h0000;

        lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        checkOutput("crc model check value", 32'(crc16(lit)), 32'h4B37);
        lit = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        checkOutput("crc model read frame", 32'(crc16(lit)), 32'h0A84);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset txv", 32'(txv), 32'd0);
        checkOutput("reset txd", 32'(txd), 32'h00);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset rd_req", 32'(hr_rd_req), 32'd0);
        checkOutput("reset rd_addr", 32'(hr_rd_addr), 32'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        lit = '{8'h02, 8'h03, 8'h02, 8'h12, 8'h34};
        applyStimulus("read1", 1'b0, 1'b1, 8'h03, 8'h00, 16'h0000, 16'd1, 16'h0, 16'h0, lit);
        wait_frame("read1", 0);

        lit = '{8'h02, 8'h83, 8'h02};
        applyStimulus("ex_wins", 1'b1, 1'b1, 8'h03, 8'h02, 16'h0000, 16'd1, 16'h0, 16'h0, lit);
        wait_frame("ex_wins", 0);

        lit = '{8'h02, 8'h83, 8'h03};
        applyStimulus("qty0", 1'b0, 1'b1, 8'h03, 8'h00, 16'h0000, 16'd0, 16'h0, 16'h0, lit);
        wait_frame("qty0", 1);
        applyStimulus("qty126", 1'b0, 1'b1, 8'h03, 8'h00, 16'h0000, 16'd126, 16'h0, 16'h0, lit);
        wait_frame("qty126", 0);

        lit = '{8'h02, 8'h03, 8'h04, 8'hBE, 8'hEF, 8'h12, 8'h34};
        applyStimulus("wrap", 1'b0, 1'b1, 8'h03, 8'h00, 16'hFFFF, 16'd2, 16'h0, 16'h0, lit);
        wait_frame("wrap", 0);

        lit = '{8'h02, 8'h10, 8'h00, 8'h10, 8'h00, 8'h03};
        applyStimulus("write10", 1'b0, 1'b1, 8'h10, 8'h00, 16'h0, 16'h0, 16'h0010, 16'd3, lit);
        wait_frame("write10", 1);

        lit = '{8'h02, 8'h17, 8'h06, 8'hC3, 8'hE5, 8'hC3, 8'hE4, 8'hC3, 8'hE7};
        applyStimulus("read17_stall", 1'b0, 1'b1, 8'h17, 8'h00, 16'h0040, 16'd3, 16'h0, 16'h0, lit);
        wait_frame("read17_stall", 2);

        lit = '{8'h02, 8'h85, 8'h01};
        applyStimulus("unsupported", 1'b0, 1'b1, 8'h05, 8'h00, 16'h0, 16'd1, 16'h0, 16'h0, lit);
        wait_frame("unsupported", 1);

        lit = '{8'h02, 8'h86, 8'h04};
        applyStimulus("ex_only", 1'b1, 1'b0, 8'h06, 8'h04, 16'h0, 16'd1, 16'h0, 16'h0, lit);
        wait_frame("ex_only", 1);

        lit = '{8'h02, 8'h03, 8'hFA};
        applyStimulus("qty_max", 1'b0, 1'b1, 8'h03, 8'h00, 16'h1000, 16'd125, 16'h0, 16'h0, lit);
        wait_frame("qty_max", 0);

        lit = '{8'h02, 8'h03, 8'h14};
        applyStimulus("abort", 1'b0, 1'b1, 8'h03, 8'h00, 16'h0100, 16'd10, 16'h0, 16'h0, lit);
        for (int c = 0; c < 200 && acc_cnt < 3; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("abort reached byte 3", 32'(acc_cnt), 32'd3);
        rst = 1'b1; tx_rdy = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort txv", 32'(txv), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort rd_addr", 32'(hr_rd_addr), 32'h0000);
        checkOutput("abort no extra bytes", 32'(acc_cnt), 32'd3);
        exp_q.delete(); exp_reads.delete();
        rst = 1'b0; tx_rdy = 1'b1;
        lit = '{8'h02, 8'h06, 8'h00, 8'h05, 8'hAB, 8'hCD};
        applyStimulus("write06", 1'b0, 1'b1, 8'h06, 8'h00, 16'h0, 16'h0, 16'h0005, 16'h0, lit);
        wait_frame("write06", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
